// File: rtl/morse_game_pkg.sv
// Shared types, widths and default timing constants for the Morse game round sequencer.
package morse_game_pkg;

   localparam int SCORE_W            = 4;
   localparam int PID_W              = 3;
   localparam int NUM_PLAYERS        = 1 << PID_W;

   localparam int DEF_NUM_ROUNDS     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1000;
   localparam int DEF_RESULT_HOLD    = 50;
   localparam int DEF_ROM_LAT        = 1;
   localparam int DEF_ROM_AW         = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_ROM,
      ST_PROMPT,
      ST_CHECK,
      ST_RESULT,
      ST_LOGOUT,
      ST_WAIT_LOW
   } state_t;

   // Sizes the shared per-state timer so it covers the longest wait.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/highscore_table.sv
// Per-player high-score register file: one write port, two combinational read ports.
module highscore_table
   import morse_game_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_we,
   input  logic [PID_W-1:0]   i_waddr,
   input  logic [SCORE_W-1:0] i_wdata,
   input  logic [PID_W-1:0]   i_raddr_a,
   output logic [SCORE_W-1:0] o_rdata_a,
   input  logic [PID_W-1:0]   i_raddr_b,
   output logic [SCORE_W-1:0] o_rdata_b
);

   logic [SCORE_W-1:0] r_mem [NUM_PLAYERS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/morse_game_ctrl.sv
// Round sequencer for the Morse game: fetch prompt, collect answer or time out, score, log out.
module morse_game_ctrl
   import morse_game_pkg::*;
#(
   parameter int NUM_ROUNDS     = DEF_NUM_ROUNDS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int RESULT_HOLD    = DEF_RESULT_HOLD,
   parameter int ROM_AW         = DEF_ROM_AW,
   parameter int ROM_LAT        = DEF_ROM_LAT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               LoggedIn,
   input  logic [PID_W-1:0]   PlayerID_from_pswd,
   input  logic               isGuest_from_PSWD,
   input  logic [3:0]         UserDigit,
   input  logic               UserLoad,
   output logic               rom_rd,
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [3:0]         rom_data,
   output logic [3:0]         prompt_code,
   output logic               prompt_valid,
   output logic [3:0]         round_idx,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_record,
   output logic               game_active,
   output logic               logout_from_gamectrl
);

   localparam int TMR_W = $clog2(max3(TIMEOUT_CYCLES, RESULT_HOLD, ROM_LAT)) + 1;
   localparam logic [TMR_W-1:0]  LAT_LAST   = TMR_W'(ROM_LAT - 1);
   localparam logic [TMR_W-1:0]  TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  HOLD_LAST  = TMR_W'(RESULT_HOLD - 1);
   localparam logic [3:0]        LAST_ROUND = 4'(NUM_ROUNDS - 1);
   localparam logic [ROM_AW-1:0] ROUNDS_A   = ROM_AW'(NUM_ROUNDS);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [TMR_W-1:0]   r_timer;
   logic [PID_W-1:0]   r_pid;
   logic [3:0]         r_round;
   logic [SCORE_W-1:0] r_score;
   logic [3:0]         r_expected;
   logic [3:0]         r_answer;
   logic               r_miss;

   logic               w_in_game;
   logic               w_abort;
   logic               w_timed;
   logic               w_rec_we;
   logic [SCORE_W-1:0] w_tbl_pid;

   assign w_in_game = r_state inside {ST_FETCH, ST_WAIT_ROM, ST_PROMPT, ST_CHECK, ST_RESULT};
   assign w_abort   = w_in_game && !LoggedIn;
   assign w_timed   = r_state inside {ST_WAIT_ROM, ST_PROMPT, ST_RESULT};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (LoggedIn) w_state_nxt = ST_FETCH;
         ST_FETCH:    w_state_nxt = ST_WAIT_ROM;
         ST_WAIT_ROM: if (r_timer == LAT_LAST) w_state_nxt = ST_PROMPT;
         // An answer in the final window cycle still lands in CHECK as an answer.
         ST_PROMPT:   if (UserLoad || r_timer == TO_LAST) w_state_nxt = ST_CHECK;
         ST_CHECK:    w_state_nxt = (r_round == LAST_ROUND) ? ST_RESULT : ST_FETCH;
         ST_RESULT:   if (r_timer == HOLD_LAST) w_state_nxt = ST_LOGOUT;
         ST_LOGOUT:   w_state_nxt = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!LoggedIn) w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
      if (w_abort) w_state_nxt = ST_IDLE;
   end

   always_comb begin
      rom_rd               = 1'b0;
      prompt_valid         = 1'b0;
      game_active          = 1'b0;
      logout_from_gamectrl = 1'b0;
      w_rec_we             = 1'b0;
      case (r_state)
         ST_FETCH: begin
            rom_rd      = 1'b1;
            game_active = 1'b1;
         end
         ST_WAIT_ROM: game_active = 1'b1;
         ST_PROMPT: begin
            prompt_valid = 1'b1;
            game_active  = 1'b1;
         end
         ST_CHECK: game_active = 1'b1;
         ST_RESULT: begin
            game_active = 1'b1;
            w_rec_we    = (r_timer == '0) && LoggedIn && !isGuest_from_PSWD
                          && (r_score > w_tbl_pid);
         end
         ST_LOGOUT: logout_from_gamectrl = 1'b1;
         default: ;
      endcase
   end

   // The timer restarts on every state change, so each timed state sees 0 on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer    <= '0;
         r_pid      <= '0;
         r_round    <= '0;
         r_score    <= '0;
         r_expected <= '0;
         r_answer   <= '0;
         r_miss     <= 1'b0;
      end else begin
         if (!w_timed || w_state_nxt != r_state) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + TMR_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (w_state_nxt == ST_FETCH) begin
                  r_score <= '0;
                  r_round <= '0;
                  r_pid   <= PlayerID_from_pswd;
               end
            end
            ST_WAIT_ROM: begin
               if (w_state_nxt == ST_PROMPT) r_expected <= rom_data;
            end
            ST_PROMPT: begin
               if (w_state_nxt == ST_CHECK) begin
                  r_answer <= UserDigit;
                  r_miss   <= !UserLoad;
               end
            end
            ST_CHECK: begin
               if (!w_abort) begin
                  if (!r_miss && r_answer == r_expected) r_score <= r_score + SCORE_W'(1);
                  if (r_round != LAST_ROUND) r_round <= r_round + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   highscore_table u_table (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_we      (w_rec_we),
      .i_waddr   (r_pid),
      .i_wdata   (r_score),
      .i_raddr_a (PlayerID_from_pswd),
      .o_rdata_a (high_score),
      .i_raddr_b (r_pid),
      .o_rdata_b (w_tbl_pid)
   );

   assign rom_addr    = ROM_AW'(r_pid) * ROUNDS_A + ROM_AW'(r_round);
   assign prompt_code = r_expected;
   assign round_idx   = r_round;
   assign score       = r_score;
   assign new_record  = w_rec_we;

endmodule

// File: tb/tb_morse_game_ctrl.sv
// Directed bench for morse_game_ctrl: four-round games against a one-cycle ROM that returns addr[3:0].
`timescale 1ns/1ps
module tb_morse_game_ctrl;

   localparam int NR  = 4;
   localparam int TO  = 20;
   localparam int RH  = 5;
   localparam int RAW = 6;
   localparam int RL  = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           LoggedIn;
   logic [2:0]     PlayerID_from_pswd;
   logic           isGuest_from_PSWD;
   logic [3:0]     UserDigit;
   logic           UserLoad;
   logic           rom_rd;
   logic [RAW-1:0] rom_addr;
   logic [3:0]     rom_data;
   logic [3:0]     prompt_code;
   logic           prompt_valid;
   logic [3:0]     round_idx;
   logic [3:0]     score;
   logic [3:0]     high_score;
   logic           new_record;
   logic           game_active;
   logic           logout_from_gamectrl;

   always #5 clk = ~clk;

   morse_game_ctrl #(
      .NUM_ROUNDS     (NR),
      .TIMEOUT_CYCLES (TO),
      .RESULT_HOLD    (RH),
      .ROM_AW         (RAW),
      .ROM_LAT        (RL)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .LoggedIn             (LoggedIn),
      .PlayerID_from_pswd   (PlayerID_from_pswd),
      .isGuest_from_PSWD    (isGuest_from_PSWD),
      .UserDigit            (UserDigit),
      .UserLoad             (UserLoad),
      .rom_rd               (rom_rd),
      .rom_addr             (rom_addr),
      .rom_data             (rom_data),
      .prompt_code          (prompt_code),
      .prompt_valid         (prompt_valid),
      .round_idx            (round_idx),
      .score                (score),
      .high_score           (high_score),
      .new_record           (new_record),
      .game_active          (game_active),
      .logout_from_gamectrl (logout_from_gamectrl)
   );

   always @(posedge clk or negedge rst) begin
      if (!rst) rom_data <= 4'd0;
      else if (rom_rd) rom_data <= rom_addr[3:0];
   end

   int             n_vec = 0;
   int             n_err = 0;
   int             n_rec = 0;
   int             n_logout = 0;
   int             exp_score = 0;
   logic [RAW-1:0] exp_q[$];
   logic [3:0]     hs_model[8];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard for ROM reads plus pulse counters, sampled on the falling edge.
   always @(negedge clk) begin
      if (new_record === 1'b1) n_rec++;
      if (logout_from_gamectrl === 1'b1) n_logout++;
      if (rom_rd === 1'b1) begin
         if (exp_q.size() == 0) check_val("rom_rd_unexpected", 32'(rom_rd), 0);
         else check_val("rom_addr", 32'(rom_addr), 32'(exp_q.pop_front()));
      end
   end

   task automatic wait_prompt(input logic [3:0] code, input logic [3:0] ridx);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = prompt_valid;
      end
      check_val("prompt_rise", 32'(seen), 1);
      check_val("prompt_code", 32'(prompt_code), 32'(code));
      check_val("round_idx", 32'(round_idx), 32'(ridx));
   endtask

   // Ends on the falling edge two cycles after the answer (or window close) cycle.
   task automatic do_round(input logic [3:0] code, input logic [3:0] ridx, input bit answer,
                           input bit wrong, input int delay);
      int n;
      wait_prompt(code, ridx);
      if (answer) begin
         repeat (delay) @(negedge clk);
         UserDigit = wrong ? code + 4'd1 : code;
         UserLoad  = 1'b1;
         @(negedge clk);
         UserLoad  = 1'b0;
      end else begin
         n = 1;
         while (prompt_valid && n < 40) begin
            @(negedge clk);
            if (prompt_valid) n++;
         end
         check_val("window_len", 32'(n), TO);
      end
      check_val("check_pv", 32'(prompt_valid), 0);
      check_val("score_pre", 32'(score), 32'(exp_score));
      if (answer && !wrong) exp_score++;
      @(negedge clk);
      check_val("score", 32'(score), 32'(exp_score));
   endtask

   task automatic play_game(input logic [2:0] pid, input bit guest, input logic [3:0] ans,
                            input logic [3:0] wrong, input int delay);
      bit rec;
      int rec0, lo0, lat;
      PlayerID_from_pswd = pid;
      isGuest_from_PSWD  = guest;
      for (int r = 0; r < NR; r++) exp_q.push_back(RAW'(int'(pid) * NR + r));
      exp_score = 0;
      rec0      = n_rec;
      lo0       = n_logout;
      LoggedIn  = 1'b1;
      for (int r = 0; r < NR; r++) begin
         do_round(4'(int'(pid) * NR + r), 4'(r), ans[r], wrong[r], (r == 0) ? delay : r);
      end
      rec = !guest && (4'(exp_score) > hs_model[pid]);
      check_val("result_ga", 32'(game_active), 1);
      check_val("new_record", 32'(new_record), 32'(rec));
      if (rec) hs_model[pid] = 4'(exp_score);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!logout_from_gamectrl && lat < 12);
      check_val("logout_lat", 32'(lat), RH);
      check_val("logout_ga", 32'(game_active), 0);
      repeat (4) @(negedge clk);
      check_val("wait_low_ga", 32'(game_active), 0);
      check_val("high_score", 32'(high_score), 32'(hs_model[pid]));
      check_val("rec_pulses", 32'(n_rec - rec0), 32'(rec));
      check_val("logout_pulses", 32'(n_logout - lo0), 1);
      LoggedIn = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
      $fatal(1);
   end

   initial begin
      int rec0, lo0;
      for (int i = 0; i < 8; i++) hs_model[i] = 4'd0;
      rst                = 1'b0;
      LoggedIn           = 1'b0;
      PlayerID_from_pswd = 3'd2;
      isGuest_from_PSWD  = 1'b0;
      UserDigit          = 4'd0;
      UserLoad           = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_rom_rd", 32'(rom_rd), 0);
      check_val("rst_rom_addr", 32'(rom_addr), 0);
      check_val("rst_prompt_valid", 32'(prompt_valid), 0);
      check_val("rst_game_active", 32'(game_active), 0);
      check_val("rst_score", 32'(score), 0);
      check_val("rst_high_score", 32'(high_score), 0);
      check_val("rst_logout", 32'(logout_from_gamectrl), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: all correct; 2: one wrong; 3: rounds 1 and 3 time out; 4: guest
      play_game(3'd2, 1'b0, 4'b1111, 4'b0000, 0);
      play_game(3'd2, 1'b0, 4'b1111, 4'b0010, 3);
      play_game(3'd1, 1'b0, 4'b0101, 4'b0000, 1);
      play_game(3'd5, 1'b1, 4'b1111, 4'b0000, 2);

      // 5: abort in the prompt of round 2
      PlayerID_from_pswd = 3'd3;
      isGuest_from_PSWD  = 1'b0;
      for (int r = 0; r < 3; r++) exp_q.push_back(RAW'(12 + r));
      exp_score = 0;
      rec0      = n_rec;
      lo0       = n_logout;
      LoggedIn  = 1'b1;
      do_round(4'd12, 4'd0, 1'b1, 1'b0, 1);
      do_round(4'd13, 4'd1, 1'b1, 1'b0, 4);
      wait_prompt(4'd14, 4'd2);
      LoggedIn = 1'b0;
      @(negedge clk);
      check_val("abort_pv", 32'(prompt_valid), 0);
      check_val("abort_ga", 32'(game_active), 0);
      check_val("abort_score", 32'(score), 32'(exp_score));
      check_val("abort_round", 32'(round_idx), 2);
      repeat (6) @(negedge clk);
      check_val("abort_logout", 32'(n_logout - lo0), 0);
      check_val("abort_rec", 32'(n_rec - rec0), 0);
      check_val("abort_hs", 32'(high_score), 32'(hs_model[3]));

      // 6a: answer in the last window cycle still counts
      play_game(3'd0, 1'b0, 4'b1111, 4'b0000, TO - 1);

      // 6b: asynchronous reset in WAIT_ROM of round 1
      PlayerID_from_pswd = 3'd2;
      exp_q.push_back(RAW'(8));
      exp_q.push_back(RAW'(9));
      exp_score = 0;
      LoggedIn  = 1'b1;
      do_round(4'd8, 4'd0, 1'b1, 1'b0, 0);
      @(negedge clk);
      check_val("pre_rst_ga", 32'(game_active), 1);
      check_val("pre_rst_hs", 32'(high_score), 32'(hs_model[2]));
      rst = 1'b0;
      #1;
      check_val("arst_rom_rd", 32'(rom_rd), 0);
      check_val("arst_rom_addr", 32'(rom_addr), 0);
      check_val("arst_prompt_code", 32'(prompt_code), 0);
      check_val("arst_prompt_valid", 32'(prompt_valid), 0);
      check_val("arst_round_idx", 32'(round_idx), 0);
      check_val("arst_score", 32'(score), 0);
      check_val("arst_high_score", 32'(high_score), 0);
      check_val("arst_new_record", 32'(new_record), 0);
      check_val("arst_game_active", 32'(game_active), 0);
      check_val("arst_logout", 32'(logout_from_gamectrl), 0);
      for (int i = 0; i < 8; i++) hs_model[i] = 4'd0;
      LoggedIn = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("post_rst_ga", 32'(game_active), 0);
      PlayerID_from_pswd = 3'd0;
      #1;
      check_val("post_rst_hs0", 32'(high_score), 32'(hs_model[0]));
      check_val("exp_q_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/morse_game_ctrl.md
Name: morse_game_ctrl

Overview:
- Round sequencer for the Morse game; runs after Authentication asserts LoggedIn.
- Per round: fetches the expected code from the pattern ROM, presents it as a prompt, and accepts one UserDigit answer or times out.
- Keeps the score and a per-player high-score table.
- At game end, pulses logout_from_gamectrl back to Authentication.

Parameters:
- NUM_ROUNDS, 8: rounds per game; legal range 1..15.
- TIMEOUT_CYCLES, 1000: answer window per round, in clk cycles.
- RESULT_HOLD, 50: cycles the final score is held before logout.
- ROM_AW, 6: pattern ROM address width; must satisfy 8*NUM_ROUNDS <= 2^ROM_AW.
- ROM_LAT, 1: cycles from rom_rd to valid rom_data; legal range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- LoggedIn  in  1  level from Authentication
- PlayerID_from_pswd  in  3  current player index
- isGuest_from_PSWD  in  1  guest session; high score is not recorded
- UserDigit  in  4  answer digit
- UserLoad  in  1  one-cycle answer strobe
- rom_rd  out  1  one-cycle ROM read strobe
- rom_addr  out  ROM_AW  address = PlayerID*NUM_ROUNDS + round
- rom_data  in  4  expected code
- prompt_code  out  4  code to be played or displayed
- prompt_valid  out  1  prompt is live, answer window open
- round_idx  out  4  current round, 0-based
- score  out  4  correct answers this game
- high_score  out  4  table entry for PlayerID_from_pswd, combinational read
- new_record  out  1  one-cycle pulse when the table is updated
- game_active  out  1  high from FETCH through RESULT
- logout_from_gamectrl  out  1  one-cycle logout pulse

Behaviour:
- Reset (rst=0, async):
  - All outputs 0, state IDLE.
  - All 8 high-score entries 0.
- States: IDLE, FETCH, WAIT_ROM, PROMPT, CHECK, RESULT, LOGOUT, WAIT_LOW.
- IDLE: when LoggedIn=1, clear score and round_idx, go to FETCH.
- FETCH: rom_rd=1 for exactly one cycle with rom_addr valid, then WAIT_ROM.
- WAIT_ROM:
  - Count ROM_LAT cycles after the rom_rd cycle.
  - Then latch rom_data into prompt_code and an internal expected register.
  - Set prompt_valid=1, clear the timeout timer, go to PROMPT.
- PROMPT:
  - UserLoad=1 captures UserDigit and goes to CHECK.
  - Otherwise, when timer reaches TIMEOUT_CYCLES-1, go to CHECK marked as a miss.
  - If UserLoad and timeout land in the same cycle, the answer wins.
  - UserLoad in any other state is ignored.
- CHECK (one cycle):
  - prompt_valid=0.
  - score += 1 when the captured digit equals expected and it was not a miss.
  - Score is visible 2 cycles after the UserLoad cycle.
  - If round_idx = NUM_ROUNDS-1, go to RESULT; otherwise round_idx += 1 and go to FETCH.
- RESULT:
  - On entry: if isGuest=0 and score > table[PlayerID], write the table and pulse new_record in that entry cycle.
  - Hold RESULT_HOLD cycles, then go to LOGOUT.
- LOGOUT: logout_from_gamectrl=1 for one cycle, game_active=0, then WAIT_LOW.
- WAIT_LOW:
  - Remain until LoggedIn=0, then IDLE.
  - This prevents an immediate restart on a stale LoggedIn.
- Abort: LoggedIn=0 in FETCH..RESULT returns to IDLE next cycle.
  - No table write, no logout pulse.
  - prompt_valid and game_active cleared.
  - score and round_idx keep their last values until the next game starts.
- Width rules:
  - Score cannot exceed NUM_ROUNDS (<=15), so no saturation is needed.
  - Table compare is unsigned, strict greater-than; ties do not update.
- PlayerID is sampled when leaving IDLE; later changes are ignored until the next game.

Decomposition:
- Shared package morse_game_pkg holds:
  - the state enum;
  - default constants for NUM_ROUNDS, TIMEOUT_CYCLES, RESULT_HOLD and ROM_LAT;
  - the SCORE_W=4 and PID_W=3 widths.
- Sub-module highscore_table:
  - 8x4 register file, async active-low clear.
  - Write port: we, waddr, wdata.
  - Combinational read port.
  - Also used later by the display block.

Test Plan (bench parameters NUM_ROUNDS=4, TIMEOUT_CYCLES=20, RESULT_HOLD=5, ROM_LAT=1; ROM model returns addr[3:0]):
1. Player 2 logs in and answers all 4 prompts correctly (rom_addr 8..11, digits 8,9,10,11) -> score=4, new_record pulses once with table[2]=4, logout pulses 5 cycles after RESULT entry.
2. Player 2 replays with 3 correct answers -> score=3, no new_record, high_score stays 4.
3. No UserLoad for rounds 1 and 3 -> each of those prompts closes exactly 20 cycles after prompt_valid rises; score=2.
4. Guest session (isGuest=1), PlayerID=5, all correct -> score=4, table[5] stays 0, no new_record, logout still pulses.
5. LoggedIn dropped during PROMPT of round 2 -> IDLE next cycle, prompt_valid=0, no logout pulse, table unchanged.
6. UserLoad arrives in the same cycle the timer hits 19, with a correct digit -> counted as correct. rst=0 asserted mid-WAIT_ROM -> all outputs 0 immediately, table cleared.
